// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: program-memory address/data, redirect controls from the
// decoder, and the registered instruction stream presented back to it.
interface fetch_unit_if;
  logic [9:0]  pc_addr;
  logic [13:0] instr_in;
  logic        stall;
  logic        jump_en;
  logic [9:0]  jump_addr;
  logic        call_en;
  logic        ret_en;
  logic [13:0] instr_out;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        stack_err;

  // Fetch-unit side: drives the address and the instruction stream.
  modport master (
    output pc_addr, instr_out, instr_pc, instr_valid, halted, stack_err,
    input  instr_in, stall, jump_en, jump_addr, call_en, ret_en
  );

  // Memory/decoder side.
  modport slave (
    input  pc_addr, instr_out, instr_pc, instr_valid, halted, stack_err,
    output instr_in, stall, jump_en, jump_addr, call_en, ret_en
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, jump/call/return redirects through a
// small return-address stack, stall hold and halt-on-HALT_WORD.
module fetch_unit #(
  parameter logic [9:0]  RESET_VECTOR = 10'h000,
  parameter logic [13:0] HALT_WORD    = 14'h0104,
  parameter int          STACK_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t          r_state;
  logic [9:0]      r_pc;
  logic [13:0]     r_instr;
  logic [9:0]      r_instr_pc;
  logic            r_valid;
  logic            r_err;
  logic [SP_W-1:0] r_sp;
  logic [9:0]      r_stack [STACK_DEPTH];

  state_t          w_state_nxt;
  logic [9:0]      w_pc_nxt;
  logic [13:0]     w_instr_nxt;
  logic [9:0]      w_instr_pc_nxt;
  logic            w_valid_nxt;
  logic            w_err_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  logic [SP_W-1:0] w_sp_m1;
  logic [9:0]      w_top;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SP_W'(STACK_DEPTH));
  assign w_sp_m1 = r_sp - SP_W'(1);
  assign w_top   = r_stack[w_sp_m1[IDX_W-1:0]];

  // Next-state and redirect decode.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_err_nxt      = r_err;
    w_push         = 1'b0;
    w_pop          = 1'b0;

    if (r_state == ST_HALT) begin
      w_state_nxt = ST_HALT;
    end else if (r_valid && (r_instr == HALT_WORD) && !bus.stall) begin
      w_state_nxt = ST_HALT;
      w_valid_nxt = 1'b0;
    end else begin
      // A return on an empty stack flags the error and falls through.
      if (bus.ret_en && w_empty) w_err_nxt = 1'b1;

      if (bus.ret_en && !w_empty) begin
        w_pop       = 1'b1;
        w_pc_nxt    = w_top;
        w_valid_nxt = 1'b0;
      end else if (bus.call_en) begin
        if (w_full) w_err_nxt = 1'b1;
        else        w_push    = 1'b1;
        w_pc_nxt    = bus.jump_addr;
        w_valid_nxt = 1'b0;
      end else if (bus.jump_en) begin
        w_pc_nxt    = bus.jump_addr;
        w_valid_nxt = 1'b0;
      end else if (!bus.stall) begin
        w_instr_nxt    = bus.instr_in;
        w_instr_pc_nxt = r_pc;
        w_valid_nxt    = 1'b1;
        w_pc_nxt       = r_pc + 10'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VECTOR;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_sp       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      if (w_push)     r_sp <= r_sp + SP_W'(1);
      else if (w_pop) r_sp <= w_sp_m1;
    end
  end

  // NOTE: stack storage is not reset; the occupancy counter alone defines
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[IDX_W-1:0]] <= r_instr_pc + 10'd1;
  end

  assign bus.pc_addr     = r_pc;
  assign bus.instr_out   = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.stack_err   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: program run to halt, stall hold, jump with PC
// wrap, call/return, stack overflow/underflow, and reset out of halt.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [13:0] mem [1024];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_VECTOR(10'h000),
    .HALT_WORD   (14'h0104),
    .STACK_DEPTH (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.instr_in = mem[bus.pc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [9:0] ipc, input logic [13:0] iout,
                         input logic vld, input logic [9:0] pc);
    check({tag, ".instr_pc"},    16'(bus.instr_pc),    16'(ipc));
    check({tag, ".instr_out"},   16'(bus.instr_out),   16'(iout));
    check({tag, ".instr_valid"}, 16'(bus.instr_valid), 16'(vld));
    check({tag, ".pc_addr"},     16'(bus.pc_addr),     16'(pc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 14'h2000 | 14'(i);
    mem[0] = 14'h0000;
    mem[1] = 14'h1001;
    mem[2] = 14'h1002;
    mem[3] = 14'h0A03;
    mem[4] = 14'h0104;
    reset = 1'b0;
    bus.stall = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = '0;
    bus.call_en = 1'b0; bus.ret_en = 1'b0;

    // Reset values
    do_reset();
    chk_out("rst", 10'h000, 14'h0000, 1'b0, 10'h000);
    check("rst.halted", 16'(bus.halted), 16'h0);
    check("rst.stack_err", 16'(bus.stack_err), 16'h0);

    // Straight-line program ending in halt
    tick(); chk_out("run0", 10'h000, 14'h0000, 1'b1, 10'h001);
    tick(); chk_out("run1", 10'h001, 14'h1001, 1'b1, 10'h002);
    tick(); chk_out("run2", 10'h002, 14'h1002, 1'b1, 10'h003);
    tick(); chk_out("run3", 10'h003, 14'h0A03, 1'b1, 10'h004);
    tick(); chk_out("run4", 10'h004, 14'h0104, 1'b1, 10'h005);
    check("run4.halted", 16'(bus.halted), 16'h0);
    tick();
    check("halt.halted", 16'(bus.halted), 16'h1);
    chk_out("halt", 10'h004, 14'h0104, 1'b0, 10'h005);
    bus.jump_en = 1'b1; bus.jump_addr = 10'h155; bus.call_en = 1'b1;
    tick(); tick();
    chk_out("halt_frozen", 10'h004, 14'h0104, 1'b0, 10'h005);
    check("halt_frozen.halted", 16'(bus.halted), 16'h1);
    check("halt_frozen.stack_err", 16'(bus.stack_err), 16'h0);
    bus.jump_en = 1'b0; bus.call_en = 1'b0;

    // Stall hold at instr_pc=2
    mem[4] = 14'h2004;
    do_reset();
    tick(); tick(); tick();
    chk_out("pre_stall", 10'h002, 14'h1002, 1'b1, 10'h003);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out($sformatf("stall%0d", i), 10'h002, 14'h1002, 1'b1, 10'h003);
    end
    bus.stall = 1'b0;
    tick(); chk_out("resume", 10'h003, 14'h0A03, 1'b1, 10'h004);

    // Jump during stall, then wrap at 3FF
    bus.stall = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 10'h3FE;
    tick(); chk_out("jmp_bubble", 10'h003, 14'h0A03, 1'b0, 10'h3FE);
    bus.stall = 1'b0; bus.jump_en = 1'b0;
    tick(); chk_out("jmp_3fe", 10'h3FE, 14'h23FE, 1'b1, 10'h3FF);
    tick(); chk_out("jmp_3ff", 10'h3FF, 14'h23FF, 1'b1, 10'h000);
    tick(); chk_out("wrap_000", 10'h000, 14'h0000, 1'b1, 10'h001);

    // Call at 0x010 to 0x100, return to 0x011
    do_reset();
    bus.jump_en = 1'b1; bus.jump_addr = 10'h010;
    tick(); chk_out("to_010", 10'h000, 14'h0000, 1'b0, 10'h010);
    bus.jump_en = 1'b0;
    tick(); chk_out("at_010", 10'h010, 14'h2010, 1'b1, 10'h011);
    bus.call_en = 1'b1; bus.jump_addr = 10'h100;
    tick(); chk_out("call", 10'h010, 14'h2010, 1'b0, 10'h100);
    bus.call_en = 1'b0;
    tick(); chk_out("at_100", 10'h100, 14'h2100, 1'b1, 10'h101);
    bus.ret_en = 1'b1;
    tick(); chk_out("ret", 10'h100, 14'h2100, 1'b0, 10'h011);
    bus.ret_en = 1'b0;
    tick(); chk_out("at_011", 10'h011, 14'h2011, 1'b1, 10'h012);
    check("callret.stack_err", 16'(bus.stack_err), 16'h0);

    // Five calls into a four-deep stack
    bus.call_en = 1'b1; bus.jump_addr = 10'h200;
    for (int i = 0; i < 4; i++) begin
      tick(); check($sformatf("call%0d.stack_err", i), 16'(bus.stack_err), 16'h0);
    end
    tick();
    check("ovf.stack_err", 16'(bus.stack_err), 16'h1);
    chk_out("ovf", 10'h011, 14'h2011, 1'b0, 10'h200);
    bus.call_en = 1'b0;
    tick(); chk_out("at_200", 10'h200, 14'h2200, 1'b1, 10'h201);

    // Simultaneous call+ret: ret wins
    bus.ret_en = 1'b1; bus.call_en = 1'b1; bus.jump_addr = 10'h300;
    tick(); chk_out("callret_both", 10'h200, 14'h2200, 1'b0, 10'h012);
    bus.call_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check($sformatf("pop%0d.pc", i), 16'(bus.pc_addr), 16'h012);
    end
    // Stack now empty: ret falls through to a normal fetch
    tick(); chk_out("unf", 10'h012, 14'h2012, 1'b1, 10'h013);
    check("unf.stack_err", 16'(bus.stack_err), 16'h1);
    bus.ret_en = 1'b0;

    // Halt with stack_err set, then reset out of it
    mem[4] = 14'h0104;
    bus.jump_en = 1'b1; bus.jump_addr = 10'h004;
    tick();
    bus.jump_en = 1'b0;
    tick(); chk_out("at_4", 10'h004, 14'h0104, 1'b1, 10'h005);
    tick();
    check("halt2.halted", 16'(bus.halted), 16'h1);
    check("halt2.stack_err", 16'(bus.stack_err), 16'h1);
    bus.stall = 1'b1;
    do_reset();
    bus.stall = 1'b0;
    chk_out("rst2", 10'h000, 14'h0000, 1'b0, 10'h000);
    check("rst2.halted", 16'(bus.halted), 16'h0);
    check("rst2.stack_err", 16'(bus.stack_err), 16'h0);
    tick(); chk_out("restart", 10'h000, 14'h0000, 1'b1, 10'h001);
    // Stack must be empty after reset: ret behaves as a normal fetch
    bus.ret_en = 1'b1;
    tick(); chk_out("rst2_ret", 10'h001, 14'h1001, 1'b1, 10'h002);
    check("rst2_ret.stack_err", 16'(bus.stack_err), 16'h1);
    bus.ret_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 10'h000, PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 14'h0104, instruction encoding that stops fetch.
REQ-003 Parameter STACK_DEPTH, default 4, return-address stack entries (1..8).
REQ-004 Port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port pc_addr  out  10  fetch address, driven to the program memory addr input.
REQ-007 Port instr_in  in  14  instruction word returned combinationally by the program memory for pc_addr.
REQ-008 Port stall  in  1  downstream not ready; hold current instruction.
REQ-009 Port jump_en  in  1  redirect fetch to jump_addr.
REQ-010 Port jump_addr  in  10  target for jump_en and call_en.
REQ-011 Port call_en  in  1  push return address, redirect to jump_addr.
REQ-012 Port ret_en  in  1  pop return address, redirect to it.
REQ-013 Port instr_out  out  14  registered instruction presented to the decoder.
REQ-014 Port instr_pc  out  10  address instr_out was fetched from.
REQ-015 Port instr_valid  out  1  instr_out is a real instruction this cycle.
REQ-016 Port halted  out  1  fetch stopped by HALT_WORD.
REQ-017 Port stack_err  out  1  sticky overflow/underflow flag.

Function
REQ-018 Normal cycle (no stall/redirect/halt): instr_out<=instr_in, instr_pc<=pc_addr, instr_valid<=1, pc_addr<=pc_addr+1; fetch-to-instr_out latency one cycle.
REQ-019 PC arithmetic modulo 1024: 10'h3FF increments to 10'h000, no flag.
REQ-020 Per-cycle priority: reset > halted > ret_en > call_en > jump_en > stall > normal.
REQ-021 Stall alone: pc_addr, instr_out, instr_pc, instr_valid all hold.
REQ-022 Redirect (jump, call, or successful ret): pc_addr<=target, instr_valid<=0 next cycle (one bubble), instr_out/instr_pc hold; redirect overrides stall.
REQ-023 Call: push instr_pc+1 (mod 1024) then redirect to jump_addr; when stack full, push discarded, stack_err<=1, redirect still taken.
REQ-024 Ret: pop top entry, redirect to it; when stack empty, stack_err<=1 and cycle is processed by the remaining priority (call_en/jump_en/stall/normal) as if ret_en were low.
REQ-025 Simultaneous call_en and ret_en with non-empty stack: ret taken, call ignored, no stack change beyond the pop.
REQ-026 Stack is LIFO of STACK_DEPTH 10-bit entries with occupancy counter 0..STACK_DEPTH; no wrap, never overwritten.
REQ-027 Halt: when instr_valid=1, instr_out==HALT_WORD and stall=0, next cycle halted<=1, instr_valid<=0, pc_addr frozen.
REQ-028 While halted: all inputs except reset ignored; state frozen; exit only via reset.
REQ-029 stack_err sticky until reset.

Reset
REQ-030 On reset (any cycle, including mid-stall, mid-redirect, or halted): pc_addr=RESET_VECTOR, instr_out=0, instr_pc=0, instr_valid=0, halted=0, stack_err=0, stack empty, on the next edge.
REQ-031 First cycle after reset deasserts: instr_in for RESET_VECTOR captured per REQ-018; instr_valid=1 one cycle later.

Verification
REQ-032 Reset, then run with memory holding nop,mov,mov,add,halt at 0..4 -> instr_pc 0,1,2,3,4 valid on consecutive cycles; halted=1 one cycle after instr_out=14'h0104; pc_addr frozen at 5.
REQ-033 stall=1 for 3 cycles at instr_pc=2 -> instr_out, instr_pc=2, pc_addr=3 held 3 cycles; resumes with instr_pc=3.
REQ-034 jump_en with jump_addr=10'h3FE during stall -> one bubble, then instr_pc 3FE, 3FF, 000 (wrap).
REQ-035 call_en at instr_pc=10'h010 with jump_addr=10'h100, later ret_en -> one bubble each; fetch resumes at 10'h011; stack_err=0.
REQ-036 STACK_DEPTH+1 calls -> stack_err=1 on last call, redirect still taken; ret on empty stack -> stack_err stays 1, PC increments normally.
REQ-037 reset asserted while halted and stack_err=1 -> all outputs per REQ-030 next cycle; fetch restarts at RESET_VECTOR.
